// File: rtl/ghost_patrol_ctrl.sv
// Patrol controller for one maze ghost: stepped path motion and player collision.
// Optional GHOST_FRONT_HIT_EN: only contact ahead of the ghost's heading counts.
module ghost_patrol_ctrl #(
    parameter int MODE         = 0,
    parameter int X_MIN        = 250,
    parameter int X_MAX        = 370,
    parameter int Y_MIN        = 165,
    parameter int Y_MAX        = 330,
    parameter int START_X      = 250,
    parameter int START_Y      = 330,
    parameter int START_DIR    = 1,
    parameter int STEP         = 3,
    parameter int TICK_DIV     = 10_000_000,
    parameter int GHOST_W      = 30,
    parameter int GHOST_H      = 30,
    parameter int PLAYER_W     = 40,
    parameter int PLAYER_H     = 40,
    parameter int ACTIVE_STAGE = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] stage_state,
    input  logic       pause,
    input  logic [9:0] people_up,
    input  logic [9:0] people_left,
    output logic [9:0] ghost_up,
    output logic [9:0] ghost_left,
    output logic [1:0] dir,
    output logic       fail,
    output logic       tick
);

    localparam logic [1:0] D_LEFT  = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_UP    = 2'd2;
    localparam logic [1:0] D_DOWN  = 2'd3;

    // A heading the path cannot use falls back to that path's natural one.
    localparam logic [1:0] INIT_DIR =
        (MODE == 1) ? ((START_DIR == 0 || START_DIR == 1) ? 2'(START_DIR) : D_RIGHT) :
        (MODE == 2) ? ((START_DIR == 2 || START_DIR == 3) ? 2'(START_DIR) : D_DOWN) :
                      2'(START_DIR);

    localparam logic [10:0] XMIN  = 11'(X_MIN);
    localparam logic [10:0] XMAX  = 11'(X_MAX);
    localparam logic [10:0] YMIN  = 11'(Y_MIN);
    localparam logic [10:0] YMAX  = 11'(Y_MAX);
    localparam logic [10:0] STEPW = 11'(STEP);
    localparam logic [10:0] GW    = 11'(GHOST_W);
    localparam logic [10:0] GH    = 11'(GHOST_H);
    localparam logic [10:0] PW    = 11'(PLAYER_W);
    localparam logic [10:0] PH    = 11'(PLAYER_H);
    localparam logic [9:0]  SX    = 10'(START_X);
    localparam logic [9:0]  SY    = 10'(START_Y);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HIT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [9:0]    gx_nxt, gy_nxt;
    logic [1:0]    dir_nxt;
    logic          fail_nxt, tick_nxt;

    logic        active;
    logic [10:0] gx, gy, px, py;
    logic [10:0] mx, my;
    logic [1:0]  mdir;
    logic        ovl, hit;

    assign active = (stage_state == 3'(ACTIVE_STAGE));
    assign gx = {1'b0, ghost_left};
    assign gy = {1'b0, ghost_up};
    assign px = {1'b0, people_left};
    assign py = {1'b0, people_up};

    assign ovl = (gx < px + PW) && (px < gx + GW) &&
                 (gy < py + PH) && (py < gy + GH);

`ifdef GHOST_FRONT_HIT_EN
    logic [10:0] gcx, gcy, pcx, pcy;
    logic        front;
    assign gcx = gx + 11'(GHOST_W / 2);
    assign gcy = gy + 11'(GHOST_H / 2);
    assign pcx = px + 11'(PLAYER_W / 2);
    assign pcy = py + 11'(PLAYER_H / 2);
    assign front = (dir == D_RIGHT) ? (pcx >= gcx) :
                   (dir == D_LEFT)  ? (pcx <= gcx) :
                   (dir == D_UP)    ? (pcy <= gcy) :
                                      (pcy >= gcy);
    assign hit = ovl & front;
`else
    assign hit = ovl;
`endif

    // One saturating step along the heading, turning on reaching the bound.
    always_comb begin
        mx   = gx;
        my   = gy;
        mdir = dir;
        case (dir)
            D_RIGHT: begin
                mx = (gx + STEPW >= XMAX) ? XMAX : gx + STEPW;
                if (mx == XMAX) mdir = (MODE == 0) ? D_UP : D_LEFT;
            end
            D_LEFT: begin
                mx = (gx < XMIN + STEPW) ? XMIN : gx - STEPW;
                if (mx == XMIN) mdir = (MODE == 0) ? D_DOWN : D_RIGHT;
            end
            D_UP: begin
                my = (gy < YMIN + STEPW) ? YMIN : gy - STEPW;
                if (my == YMIN) mdir = (MODE == 0) ? D_LEFT : D_DOWN;
            end
            default: begin
                my = (gy + STEPW >= YMAX) ? YMAX : gy + STEPW;
                if (my == YMAX) mdir = (MODE == 0) ? D_RIGHT : D_UP;
            end
        endcase
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gx_nxt    = ghost_left;
        gy_nxt    = ghost_up;
        dir_nxt   = dir;
        fail_nxt  = fail;
        tick_nxt  = 1'b0;
        if (!active) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            gx_nxt    = SX;
            gy_nxt    = SY;
            dir_nxt   = INIT_DIR;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_nxt = S_RUN;
                    fail_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    gx_nxt    = SX;
                    gy_nxt    = SY;
                    dir_nxt   = INIT_DIR;
                end
                S_RUN: begin
                    if (hit) begin
                        state_nxt = S_HIT;
                        fail_nxt  = 1'b1;
                    end
                    if (!pause) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt  = '0;
                            tick_nxt = 1'b1;
                            gx_nxt   = mx[9:0];
                            gy_nxt   = my[9:0];
                            dir_nxt  = mdir;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                S_HIT: begin
                    state_nxt = S_HIT;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset returns to the start pose.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ghost_left <= SX;
            ghost_up   <= SY;
            dir        <= INIT_DIR;
            fail       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ghost_left <= gx_nxt;
            ghost_up   <= gy_nxt;
            dir        <= dir_nxt;
            fail       <= fail_nxt;
            tick       <= tick_nxt;
        end
    end

endmodule
